// File: rtl/cmp_pkg.sv
// Shared types for the comparator probe engine.
//   scan_state_t : probe FSM states
//   DefaultWidth / DefaultSettle : default operand width and settle interval
//   cmp_flags_t  : {R, G, B} flag bundle returned by the comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StFinish
    } scan_state_t;

    localparam int unsigned DefaultWidth  = 2;
    localparam int unsigned DefaultSettle = 2;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } cmp_flags_t;

endpackage

// File: rtl/cmp_probe_scan.sv
// Probe engine driving the `b` operand of the 2-bit comparator/RGB-flag block.
// Steps b through 0..2^WIDTH-1, holds each candidate SETTLE+1 cycles, and
// reports the first candidate for which the comparator flags equality (B low).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           scan request, honoured only when idle
//   R, G, B         comparator flags (B=0 means a == b; R/G are status only)
//   b               candidate driven to the comparator
//   busy, done      scan in progress / one-cycle completion pulse
//   found, value    match flag and matched candidate (0 when no match)
//   rg              {R,G} captured at the deciding probe
//   probes          probe count of the last scan (CMP_PROBE_COUNT_EN only)
//
// Build option: define CMP_PROBE_COUNT_EN to add the probe counter and the
// `probes` output.
module cmp_probe_scan
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned SETTLE = DefaultSettle
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             R,
    input  logic             G,
    input  logic             B,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] value,
    output logic [1:0]       rg
`ifdef CMP_PROBE_COUNT_EN
    ,
    output logic [WIDTH:0]   probes
`endif
);

    localparam int unsigned       CntW    = $clog2(SETTLE + 1);
    localparam logic [CntW-1:0]   CntLast = CntW'(SETTLE - 1);
    localparam logic [WIDTH-1:0]  BLast   = '1;

    scan_state_t      state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] value_q;
    logic             busy_q;
    logic             done_q;
    logic             found_q;
    logic [1:0]       rg_q;
    cmp_flags_t       flags;

    assign flags = {R, G, B};

`ifdef CMP_PROBE_COUNT_EN
    logic [WIDTH:0] probes_q;
    assign probes = probes_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            b_q      <= '0;
            value_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            rg_q     <= '0;
`ifdef CMP_PROBE_COUNT_EN
            probes_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        b_q      <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        found_q  <= 1'b0;
                        value_q  <= '0;
                        rg_q     <= '0;
`ifdef CMP_PROBE_COUNT_EN
                        probes_q <= '0;
`endif
                        state_q  <= StSettle;
                    end
                end
                StSettle: begin
                    cnt_q <= cnt_q + 1'b1;
                    // SETTLE cycles here plus the SAMPLE cycle give SETTLE+1 of hold.
                    if (cnt_q == CntLast) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
`ifdef CMP_PROBE_COUNT_EN
                    probes_q <= probes_q + 1'b1;
`endif
                    if (!flags.b) begin
                        value_q <= b_q;
                        found_q <= 1'b1;
                        rg_q    <= {flags.r, flags.g};
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else if (b_q == BLast) begin
                        value_q <= '0;
                        found_q <= 1'b0;
                        rg_q    <= {flags.r, flags.g};
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        b_q     <= b_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= StSettle;
                    end
                end
                StFinish: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign b     = b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign value = value_q;
    assign rg    = rg_q;

endmodule
